qmem_upsizer: RTL and testbench

QMEM_UPSIZER -- requirements
Module: qmem_upsizer

---
 rtl/qmem_upsizer.sv | 155 +++++++++++++++
 tb/tb_qmem_upsizer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/qmem_upsizer.sv
// Bridges a 16-bit halfword master onto a 32-bit big-endian word slave,
// with a one-word read buffer that serves repeat reads of the last word fetched.
module qmem_upsizer #(
    parameter int AW = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [AW-1:0] m_adr,
    input  logic          m_cs,
    input  logic          m_we,
    input  logic [1:0]    m_sel,
    input  logic [15:0]   m_dat_w,
    output logic [15:0]   m_dat_r,
    output logic          m_ack,
    output logic          m_err,
    output logic [AW-1:0] s_adr,
    output logic          s_cs,
    output logic          s_we,
    output logic [3:0]    s_sel,
    output logic [31:0]   s_dat_w,
    input  logic [31:0]   s_dat_r,
    input  logic          s_ack,
    input  logic          s_err
);

    typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_WR, ST_ACK, ST_ERR} state_t;

    state_t          state_q;
    logic [AW-1:0]   s_adr_q;
    logic            s_cs_q;
    logic            s_we_q;
    logic [3:0]      s_sel_q;
    logic [31:0]     s_dat_w_q;
    logic [15:0]     m_dat_r_q;
    logic            m_ack_q;
    logic            m_err_q;
    logic [31:0]     buf_dat_q;
    logic [AW-1:2]   buf_adr_q;
    logic            buf_vld_q;
    logic            hw_q;

    logic            rd_hit_d;
    logic            wr_same_d;
    logic            unused_adr0;

    function automatic logic [15:0] hw_sel(input logic [31:0] w, input logic lo_half);
        return lo_half ? w[15:0] : w[31:16];
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // A flush in the sampling cycle must turn a would-be hit into a miss.
    assign rd_hit_d    = buf_vld_q && (m_adr[AW-1:2] == buf_adr_q) && !flush;
    assign wr_same_d   = buf_vld_q && (s_adr_q[AW-1:2] == buf_adr_q);
    assign unused_adr0 = m_adr[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            s_adr_q   <= '0;
            s_cs_q    <= 1'b0;
            s_we_q    <= 1'b0;
            s_sel_q   <= '0;
            s_dat_w_q <= '0;
            m_dat_r_q <= '0;
            m_ack_q   <= 1'b0;
            m_err_q   <= 1'b0;
            buf_dat_q <= '0;
            buf_adr_q <= '0;
            buf_vld_q <= 1'b0;
            hw_q      <= 1'b0;
        end else begin
            m_ack_q <= 1'b0;
            m_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (m_cs) begin
                        if (!m_we && rd_hit_d) begin
                            m_dat_r_q <= hw_sel(buf_dat_q, m_adr[1]);
                            m_ack_q   <= 1'b1;
                            state_q   <= ST_ACK;
                        end else begin
                            s_cs_q  <= 1'b1;
                            s_we_q  <= m_we;
                            s_adr_q <= {m_adr[AW-1:2], 2'b00};
                            hw_q    <= m_adr[1];
                            if (m_we) begin
                                s_sel_q   <= m_adr[1] ? {2'b00, m_sel} : {m_sel, 2'b00};
                                s_dat_w_q <= m_adr[1] ? {16'h0, m_dat_w} : {m_dat_w, 16'h0};
                                state_q   <= ST_WR;
                            end else begin
                                s_sel_q <= 4'b1111;
                                state_q <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (s_err) begin
                        s_cs_q    <= 1'b0;
                        buf_vld_q <= 1'b0;
                        m_err_q   <= 1'b1;
                        state_q   <= ST_ERR;
                    end else if (s_ack) begin
                        s_cs_q    <= 1'b0;
                        buf_dat_q <= s_dat_r;
                        buf_adr_q <= s_adr_q[AW-1:2];
                        buf_vld_q <= 1'b1;
                        m_dat_r_q <= hw_sel(s_dat_r, hw_q);
                        m_ack_q   <= 1'b1;
                        state_q   <= ST_ACK;
                    end
                end
                ST_WR: begin
                    if (s_err) begin
                        s_cs_q    <= 1'b0;
                        buf_vld_q <= 1'b0;
                        m_err_q   <= 1'b1;
                        state_q   <= ST_ERR;
                    end else if (s_ack) begin
                        s_cs_q <= 1'b0;
                        if (wr_same_d) buf_dat_q <= byte_merge(buf_dat_q, s_dat_w_q, s_sel_q);
                        m_ack_q <= 1'b1;
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK:  state_q <= ST_IDLE;
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
            // Placed last so a flush overrides a buffer fill in the same cycle.
            if (flush) buf_vld_q <= 1'b0;
        end
    end

    assign s_adr   = s_adr_q;
    assign s_cs    = s_cs_q;
    assign s_we    = s_we_q;
    assign s_sel   = s_sel_q;
    assign s_dat_w = s_dat_w_q;
    assign m_dat_r = m_dat_r_q;
    assign m_ack   = m_ack_q;
    assign m_err   = m_err_q;

endmodule

// File: tb/tb_qmem_upsizer.sv
// Randomized bench for qmem_upsizer: a word-memory slave plus a read-buffer model
// predict every slave request and master response.
module tb_qmem_upsizer;
    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          rst, flush, m_cs, m_we, m_ack, m_err, s_cs, s_we, s_ack, s_err;
    logic [AW-1:0] m_adr, s_adr;
    logic [1:0]    m_sel;
    logic [15:0]   m_dat_w, m_dat_r;
    logic [3:0]    s_sel;
    logic [31:0]   s_dat_w, s_dat_r;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [int];
    bit          mvld;
    int          madr;
    logic [31:0] mdat;

    always #5 clk = ~clk;

    qmem_upsizer #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .m_adr(m_adr), .m_cs(m_cs), .m_we(m_we), .m_sel(m_sel), .m_dat_w(m_dat_w),
        .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
        .s_adr(s_adr), .s_cs(s_cs), .s_we(s_we), .s_sel(s_sel), .s_dat_w(s_dat_w),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int w);
        if (mem.exists(w)) return mem[w];
        return {w[15:0] ^ 16'h5A5A, ~w[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    function automatic logic [15:0] half(input logic [31:0] w, input logic a1);
        return a1 ? 16'(w & 32'h0000FFFF) : 16'(w >> 16);
    endfunction

    // Runs one master transfer, acting as the slave with random latency.
    task automatic do_txn(input bit we, input logic [AW-1:0] adr, input logic [1:0] sel,
                          input logic [15:0] wd, input bit err, input bit fl_req,
                          input bit fl_ack, input bit keep_cs);
        int          wi;
        bit          hit, done, responded, prev_scs;
        int          scs_rise, lat;
        logic [3:0]  esel;
        logic [31:0] edat;
        logic [15:0] exp_rd;
        wi        = int'(adr[AW-1:2]);
        hit       = !we && mvld && (madr == wi) && !fl_req;
        exp_rd    = hit ? half(mdat, adr[1]) : half(mem_rd(wi), adr[1]);
        if (fl_req) mvld = 1'b0;
        esel      = adr[1] ? {2'b00, sel} : ({2'b00, sel} << 2);
        edat      = adr[1] ? {16'h0, wd} : ({16'h0, wd} << 16);
        lat       = $urandom_range(0, 3);
        done      = 0;
        responded = 0;
        prev_scs  = 0;
        scs_rise  = 0;
        m_cs = 1'b1; m_we = we; m_adr = adr; m_sel = sel; m_dat_w = wd; flush = fl_req;
        for (int it = 1; it <= 40 && !done; it++) begin
            @(posedge clk); #1;
            flush = 1'b0; s_ack = 1'b0; s_err = 1'b0;
            if (m_ack || m_err) begin
                done = 1;
                chk("ack_err_excl", {31'b0, m_ack & m_err}, 32'd0);
                if (hit) chk("hit_latency", it, 1);
                chk("slave_req_count", scs_rise, hit ? 0 : 1);
                chk("s_cs_dropped", {31'b0, s_cs}, 32'd0);
                if (err && !hit) begin
                    chk("m_err", {31'b0, m_err}, 32'd1);
                    chk("m_ack_on_err", {31'b0, m_ack}, 32'd0);
                end else begin
                    chk("m_ack", {31'b0, m_ack}, 32'd1);
                    if (!we) chk("rdata", {16'h0, m_dat_r}, {16'h0, exp_rd});
                end
            end else if (s_cs) begin
                if (!prev_scs) begin
                    scs_rise++;
                    if (scs_rise == 1) chk("s_cs_start", it, 1);
                end
                chk("s_we", {31'b0, s_we}, {31'b0, we});
                chk("s_adr", 32'(s_adr), 32'({adr[AW-1:2], 2'b00}));
                chk("s_sel", {28'b0, s_sel}, {28'b0, we ? esel : 4'hF});
                if (we) chk("s_dat_w", s_dat_w, edat);
                if (!responded) begin
                    if (lat == 0) begin
                        responded = 1;
                        if (err) begin
                            s_err = 1'b1;
                            mvld  = 1'b0;
                        end else begin
                            s_ack = 1'b1;
                            if (we) begin
                                mem[wi] = merge(mem_rd(wi), edat, esel);
                                if (mvld && madr == wi) mdat = merge(mdat, edat, esel);
                            end else begin
                                s_dat_r = mem_rd(wi);
                                mdat    = s_dat_r;
                                madr    = wi;
                                mvld    = 1'b1;
                            end
                        end
                        if (fl_ack) begin
                            flush = 1'b1;
                            mvld  = 1'b0;
                        end
                    end else begin
                        lat--;
                    end
                end
            end
            prev_scs = s_cs;
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
        s_ack = 1'b0; s_err = 1'b0; flush = 1'b0;
        m_cs = keep_cs;
        @(posedge clk); #1;
        chk("resp_one_cycle", {31'b0, m_ack | m_err}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; m_cs = 1'b0; m_we = 1'b0; m_adr = '0; m_sel = 2'b00;
        m_dat_w = '0; s_dat_r = '0; s_ack = 1'b0; s_err = 1'b0;
        mvld = 1'b0; madr = 0; mdat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_cs", {31'b0, s_cs}, 32'd0);
        chk("rst_s_we", {31'b0, s_we}, 32'd0);
        chk("rst_m_ack", {31'b0, m_ack}, 32'd0);
        chk("rst_m_err", {31'b0, m_err}, 32'd0);
        chk("rst_s_adr", 32'(s_adr), 32'd0);
        chk("rst_s_sel", {28'b0, s_sel}, 32'd0);
        chk("rst_s_dat_w", s_dat_w, 32'd0);
        chk("rst_m_dat_r", {16'h0, m_dat_r}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Miss then hit, write merge.
        mem[32'h40] = 32'h12345678;
        do_txn(0, 22'h000100, 2'b11, 16'h0, 0, 0, 0, 0);
        chk("miss_data_const", {16'h0, m_dat_r}, 32'h1234);
        do_txn(0, 22'h000102, 2'b11, 16'h0, 0, 0, 0, 0);
        chk("hit_data_const", {16'h0, m_dat_r}, 32'h5678);
        do_txn(1, 22'h000102, 2'b01, 16'h00AB, 0, 0, 0, 0);
        do_txn(0, 22'h000102, 2'b11, 16'h0, 0, 0, 0, 0);
        chk("merge_data_const", {16'h0, m_dat_r}, 32'h56AB);

        // Error, then the same word must miss.
        do_txn(0, 22'h000200, 2'b11, 16'h0, 1, 0, 0, 0);
        do_txn(0, 22'h000200, 2'b11, 16'h0, 0, 0, 0, 0);
        // Flush races.
        do_txn(0, 22'h000202, 2'b11, 16'h0, 0, 1, 0, 0);
        do_txn(0, 22'h000100, 2'b11, 16'h0, 0, 0, 1, 0);
        do_txn(0, 22'h000100, 2'b11, 16'h0, 0, 0, 0, 0);

        // Reset in the middle of a slave read.
        m_cs = 1'b1; m_we = 1'b0; m_adr = 22'h000400;
        @(posedge clk); #1;
        chk("rd_started", {31'b0, s_cs}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m_cs = 1'b0; mvld = 1'b0;
        chk("rst_abandon_s_cs", {31'b0, s_cs}, 32'd0);
        chk("rst_abandon_ack", {31'b0, m_ack}, 32'd0);
        s_ack = 1'b1; s_dat_r = 32'hDEADBEEF;
        @(posedge clk); #1;
        s_ack = 1'b0;
        chk("late_ack_m_ack", {31'b0, m_ack}, 32'd0);
        chk("late_ack_s_cs", {31'b0, s_cs}, 32'd0);
        @(posedge clk); #1;
        chk("late_ack_quiet", {30'b0, m_ack, m_err}, 32'd0);
        do_txn(0, 22'h000400, 2'b11, 16'h0, 0, 0, 0, 0);

        // Back-to-back with m_cs held across m_ack.
        do_txn(0, 22'h000100, 2'b11, 16'h0, 0, 0, 0, 1);
        do_txn(0, 22'h000300, 2'b11, 16'h0, 0, 0, 0, 1);
        do_txn(1, 22'h000300, 2'b10, 16'hC3C3, 0, 0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            int          pick;
            int          w;
            logic [AW-1:0] a;
            pick = $urandom_range(0, 5);
            w    = (pick < 4) ? (32'h40 + pick) : ((pick == 4) ? 32'h80 : 32'hC0);
            a    = AW'(w << 2) | AW'($urandom_range(0, 3));
            do_txn($urandom_range(0, 2) == 0, a, 2'($urandom_range(0, 3)),
                   16'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
        end
        m_cs = 1'b0;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
